// File: rtl/mdu_seq_if.sv
// Bundle of decode, multiplier/divider and HI/LO write-port signals seen by mdu_seq.
// The slave modport is the sequencer's view; master is the surrounding pipeline and units.
interface mdu_seq_if;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hilo_rd;
   logic        flush;

   logic        mul_start;
   logic        div_start;
   logic        mul_signed;
   logic        div_signed;
   logic [31:0] op_a;
   logic [31:0] op_b;

   logic        mul_done;
   logic [31:0] mul_hi;
   logic [31:0] mul_lo;
   logic        div_done;
   logic [31:0] div_q;
   logic [31:0] div_r;

   logic        hi_we;
   logic        lo_we;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;

   logic        busy;
   logic        stall;
   logic        err;

   modport slave (
      input  op_valid, op, rs_val, rt_val, hilo_rd, flush,
      input  mul_done, mul_hi, mul_lo, div_done, div_q, div_r,
      output mul_start, div_start, mul_signed, div_signed, op_a, op_b,
      output hi_we, lo_we, hi_wdata, lo_wdata, busy, stall, err
   );

   modport master (
      output op_valid, op, rs_val, rt_val, hilo_rd, flush,
      output mul_done, mul_hi, mul_lo, div_done, div_q, div_r,
      input  mul_start, div_start, mul_signed, div_signed, op_a, op_b,
      input  hi_we, lo_we, hi_wdata, lo_wdata, busy, stall, err
   );
endinterface

// File: rtl/mdu_seq.sv
// HI/LO sequencer: launches the external multiplier/divider, waits for completion
// with a timeout, and writes HI/LO back in a single WB cycle.
module mdu_seq #(
   parameter int TIMEOUT = 40
) (
   input  logic     clk,
   input  logic     reset,
   mdu_seq_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, WB} state_t;

   state_t        state_reg;
   logic [CW-1:0] wait_cnt_reg;
   logic          mul_start_reg;
   logic          div_start_reg;
   logic          mul_signed_reg;
   logic          div_signed_reg;
   logic [31:0]   op_a_reg;
   logic [31:0]   op_b_reg;
   logic          hi_we_reg;
   logic          lo_we_reg;
   logic [31:0]   hi_wdata_reg;
   logic [31:0]   lo_wdata_reg;
   logic          err_reg;

   logic          legal_op;
   logic          accept;

   assign legal_op = (bus.op <= OP_MTLO);
   assign accept   = (state_reg == IDLE) && bus.op_valid && legal_op && !bus.flush;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         wait_cnt_reg   <= '0;
         mul_start_reg  <= 1'b0;
         div_start_reg  <= 1'b0;
         mul_signed_reg <= 1'b0;
         div_signed_reg <= 1'b0;
         op_a_reg       <= '0;
         op_b_reg       <= '0;
         hi_we_reg      <= 1'b0;
         lo_we_reg      <= 1'b0;
         hi_wdata_reg   <= '0;
         lo_wdata_reg   <= '0;
         err_reg        <= 1'b0;
      end else begin
         // Strobes are single-cycle unless a branch below re-arms them.
         mul_start_reg <= 1'b0;
         div_start_reg <= 1'b0;
         hi_we_reg     <= 1'b0;
         lo_we_reg     <= 1'b0;
         err_reg       <= 1'b0;

         if (bus.flush) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (accept) begin
                     op_a_reg       <= bus.rs_val;
                     op_b_reg       <= bus.rt_val;
                     mul_signed_reg <= (bus.op == OP_MULT);
                     div_signed_reg <= (bus.op == OP_DIV);
                     wait_cnt_reg   <= '0;
                     case (bus.op)
                        OP_MULT, OP_MULTU: begin
                           state_reg     <= MUL_WAIT;
                           mul_start_reg <= 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                           if (bus.rt_val == 32'd0) begin
                              // Divide by zero never reaches the divider.
                              state_reg    <= WB;
                              hi_we_reg    <= 1'b1;
                              lo_we_reg    <= 1'b1;
                              hi_wdata_reg <= bus.rs_val;
                              lo_wdata_reg <= 32'hFFFF_FFFF;
                           end else begin
                              state_reg     <= DIV_WAIT;
                              div_start_reg <= 1'b1;
                           end
                        end
                        OP_MTHI: begin
                           state_reg    <= WB;
                           hi_we_reg    <= 1'b1;
                           hi_wdata_reg <= bus.rs_val;
                        end
                        default: begin
                           state_reg    <= WB;
                           lo_we_reg    <= 1'b1;
                           lo_wdata_reg <= bus.rs_val;
                        end
                     endcase
                  end
               end

               MUL_WAIT: begin
                  if (bus.mul_done) begin
                     state_reg    <= WB;
                     hi_we_reg    <= 1'b1;
                     lo_we_reg    <= 1'b1;
                     hi_wdata_reg <= bus.mul_hi;
                     lo_wdata_reg <= bus.mul_lo;
                  end else if (wait_cnt_reg == WAIT_LAST) begin
                     state_reg <= IDLE;
                     err_reg   <= 1'b1;
                  end else begin
                     wait_cnt_reg <= wait_cnt_reg + 1'b1;
                  end
               end

               DIV_WAIT: begin
                  if (bus.div_done) begin
                     state_reg    <= WB;
                     hi_we_reg    <= 1'b1;
                     lo_we_reg    <= 1'b1;
                     hi_wdata_reg <= bus.div_r;
                     lo_wdata_reg <= bus.div_q;
                  end else if (wait_cnt_reg == WAIT_LAST) begin
                     state_reg <= IDLE;
                     err_reg   <= 1'b1;
                  end else begin
                     wait_cnt_reg <= wait_cnt_reg + 1'b1;
                  end
               end

               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   // Reset and flush squash strobes already in flight this cycle.
   assign bus.busy       = (state_reg != IDLE) && !reset;
   assign bus.stall      = bus.busy && (bus.op_valid || bus.hilo_rd);
   assign bus.mul_start  = mul_start_reg && !bus.flush && !reset;
   assign bus.div_start  = div_start_reg && !bus.flush && !reset;
   assign bus.hi_we      = hi_we_reg && !bus.flush && !reset;
   assign bus.lo_we      = lo_we_reg && !bus.flush && !reset;
   assign bus.err        = err_reg && !bus.flush && !reset;
   assign bus.hi_wdata   = reset ? 32'd0 : hi_wdata_reg;
   assign bus.lo_wdata   = reset ? 32'd0 : lo_wdata_reg;
   assign bus.mul_signed = mul_signed_reg;
   assign bus.div_signed = div_signed_reg;
   assign bus.op_a       = op_a_reg;
   assign bus.op_b       = op_b_reg;
endmodule
